// File: rtl/intc_vec.sv
// rtl/intc_vec.sv - sticky-pending interrupt controller with masked, fixed-priority or round-robin vectoring
module intc_vec #(
  parameter int                 N_SRC      = 4,
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  VEC_BASE   = ADDR_W'(32'h0000_0100),
  parameter int                 VEC_STRIDE = 4,
  parameter bit                 RR_MODE    = 1'b0,
  localparam int                ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  done,
  input  logic              mask_we,
  input  logic [N_SRC-1:0]  mask_wdata,
  input  logic              iack,
  output logic              irq,
  output logic [ADDR_W-1:0] EAddr,
  output logic [ID_W-1:0]   irq_id,
  output logic [N_SRC-1:0]  pending
);

  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

  state_t             state;
  state_t             state_next;
  logic [N_SRC-1:0]   mask;
  logic [N_SRC-1:0]   req;
  logic [N_SRC-1:0]   clr;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win;
  logic               capture;
  logic               ack;

  assign req = pending & mask;

  // Clear mask for the presented source, applied only on the acknowledging edge.
  assign clr = ack ? (N_SRC'(1) << irq_id) : '0;

  // Winner select: scan from the round-robin pointer (or from 0), wrapping at N_SRC.
  always_comb begin : pick_winner
    int               idx;
    logic             found;
    logic [N_SRC-1:0] sh;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    sh    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = RR_MODE ? (int'(ptr) + k) : k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      sh = req >> idx;
      if (!found && sh[0]) begin
        win   = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  // Next-state logic: IDLE captures a request, ASSERT waits for iack, GAP is one dead cycle.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    ack        = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          capture    = 1'b1;
          state_next = ASSERT;
        end
      end
      ASSERT: begin
        if (iack) begin
          ack        = 1'b1;
          state_next = GAP;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Sticky pending bits (a new event beats a same-edge clear) and the mask register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      mask    <= '1;
    end else begin
      pending <= (pending & ~clr) | done;
      if (mask_we) mask <= mask_wdata;
    end
  end

  // Presented request: frozen from capture until iack; the pointer advances past the serviced source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq    <= 1'b0;
      irq_id <= '0;
      EAddr  <= VEC_BASE;
      ptr    <= '0;
    end else if (capture) begin
      irq    <= 1'b1;
      irq_id <= win;
      EAddr  <= VEC_BASE + ADDR_W'(win) * ADDR_W'(VEC_STRIDE);
    end else if (ack) begin
      irq <= 1'b0;
      if (irq_id == ID_W'(N_SRC - 1)) ptr <= '0;
      else                            ptr <= irq_id + ID_W'(1);
    end
  end

endmodule

// File: tb/tb_intc_vec.sv
// tb/tb_intc_vec.sv - randomized and directed bench for intc_vec in both arbitration modes
module tb_intc_vec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  done = '0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_wdata = '0;
  logic        iack [2];
  logic        irq_o [2];
  logic [31:0] eaddr_o [2];
  logic [1:0]  id_o [2];
  logic [3:0]  pend_o [2];

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state, index 0 = fixed priority, 1 = round-robin.
  bit [3:0] m_pend [2];
  bit [3:0] m_mask [2];
  bit       m_busy [2];
  int       m_cool [2];
  int       m_id   [2];
  int       m_ptr  [2];

  int       rr_seq [$];
  bit       rr_prev;

  always #5 clk = ~clk;

  intc_vec #(.RR_MODE(1'b0)) u_fp (
    .clk(clk), .rst(rst), .done(done), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .iack(iack[0]), .irq(irq_o[0]), .EAddr(eaddr_o[0]), .irq_id(id_o[0]), .pending(pend_o[0])
  );

  intc_vec #(.RR_MODE(1'b1)) u_rr (
    .clk(clk), .rst(rst), .done(done), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .iack(iack[1]), .irq(irq_o[1]), .EAddr(eaddr_o[1]), .irq_id(id_o[1]), .pending(pend_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int m, input bit [3:0] req);
    bit [7:0] rot;
    if (m == 0) begin
      for (int i = 0; i < 4; i++) if (req[i]) return i;
    end else begin
      rot = {req, req} >> m_ptr[m];
      for (int i = 0; i < 4; i++) if (rot[i]) return (i + m_ptr[m]) % 4;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = '0;
      m_mask[m] = 4'hF;
      m_busy[m] = 1'b0;
      m_cool[m] = 0;
      m_id[m]   = 0;
      m_ptr[m]  = 0;
    end
  endtask

  // One clock edge of the model; all decisions use values from before the edge.
  task automatic model_edge();
    bit [3:0] req;
    bit [3:0] clear;
    for (int m = 0; m < 2; m++) begin
      req   = m_pend[m] & m_mask[m];
      clear = '0;
      if (m_busy[m]) begin
        if (iack[m]) begin
          clear     = 4'(1 << m_id[m]);
          m_busy[m] = 1'b0;
          m_cool[m] = 1;
          m_ptr[m]  = (m_id[m] + 1) % 4;
        end
      end else if (m_cool[m] != 0) begin
        m_cool[m] = 0;
      end else if (req != 0) begin
        m_id[m]   = pick(m, req);
        m_busy[m] = 1'b1;
      end
      m_pend[m] = (m_pend[m] & ~clear) | done;
      if (mask_we) m_mask[m] = mask_wdata;
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d.irq", m),   32'(irq_o[m]),  32'(m_busy[m]));
      check($sformatf("m%0d.id", m),    32'(id_o[m]),   32'(m_id[m]));
      check($sformatf("m%0d.eaddr", m), eaddr_o[m],     32'h100 + 32'(m_id[m]) * 32'd4);
      check($sformatf("m%0d.pend", m),  32'(pend_o[m]), 32'(m_pend[m]));
    end
  endtask

  // Apply the currently driven inputs at one edge, check, then return pulse inputs to idle.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (irq_o[1] && !rr_prev) rr_seq.push_back(int'(id_o[1]));
    rr_prev    = irq_o[1];
    done       = '0;
    mask_we    = 1'b0;
    iack[0]    = 1'b0;
    iack[1]    = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      iack[0] = irq_o[0];
      iack[1] = irq_o[1];
      tick();
    end
  endtask

  initial begin
    iack[0] = 1'b0;
    iack[1] = 1'b0;
    rr_prev = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      check("rst.irq",   32'(irq_o[m]),  32'd0);
      check("rst.id",    32'(id_o[m]),   32'd0);
      check("rst.eaddr", eaddr_o[m],     32'h100);
      check("rst.pend",  32'(pend_o[m]), 32'd0);
    end
    rst = 1'b1;

    // Single done[2] pulse, then acknowledge
    done = 4'b0100;
    tick();
    check("t1.pend", 32'(pend_o[0]), 32'h4);
    check("t1.irq_early", 32'(irq_o[0]), 32'd0);
    tick();
    check("t1.irq",   32'(irq_o[0]), 32'd1);
    check("t1.id",    32'(id_o[0]),  32'd2);
    check("t1.eaddr", eaddr_o[0],    32'h108);
    tick();
    iack[0] = 1'b1;
    iack[1] = 1'b1;
    tick();
    check("t1.irq_off", 32'(irq_o[0]),  32'd0);
    check("t1.pend0",   32'(pend_o[0]), 32'd0);
    tick();
    tick();

    // Two sources in one cycle: fixed priority serves 1 then 3
    done = 4'b1010;
    tick();
    tick();
    check("t2.id1",    32'(id_o[0]), 32'd1);
    check("t2.eaddr1", eaddr_o[0],   32'h104);
    iack[0] = 1'b1;
    iack[1] = 1'b1;
    tick();
    check("t2.gap", 32'(irq_o[0]), 32'd0);
    tick();
    check("t2.gap2", 32'(irq_o[0]), 32'd0);
    tick();
    check("t2.irq3",   32'(irq_o[0]), 32'd1);
    check("t2.id3",    32'(id_o[0]),  32'd3);
    check("t2.eaddr3", eaddr_o[0],    32'h10C);
    iack[0] = 1'b1;
    iack[1] = 1'b1;
    tick();
    drain(3);
    check("t2.pend_fp", 32'(pend_o[0]), 32'd0);
    check("t2.pend_rr", 32'(pend_o[1]), 32'd0);

    // Round-robin: done[0] held, done[1] pulsed once
    rr_seq.delete();
    for (int i = 0; i < 10; i++) begin
      done    = (i == 0) ? 4'b0011 : 4'b0001;
      iack[0] = irq_o[0];
      iack[1] = irq_o[1];
      tick();
    end
    drain(10);
    check("t3.nseq", 32'(rr_seq.size() >= 3), 32'd1);
    if (rr_seq.size() >= 3) begin
      check("t3.seq0", 32'(rr_seq[0]), 32'd0);
      check("t3.seq1", 32'(rr_seq[1]), 32'd1);
      check("t3.seq2", 32'(rr_seq[2]), 32'd0);
    end

    // Masked source latches but does not request until unmasked
    mask_we = 1'b1;
    mask_wdata = 4'b1110;
    tick();
    done = 4'b0001;
    tick();
    repeat (3) tick();
    check("t4.pend", 32'(pend_o[0]), 32'h1);
    check("t4.irq",  32'(irq_o[0]),  32'd0);
    mask_we = 1'b1;
    mask_wdata = 4'b1111;
    tick();
    check("t4.irq_w", 32'(irq_o[0]), 32'd0);
    tick();
    check("t4.irq_on", 32'(irq_o[0]), 32'd1);
    check("t4.id",     32'(id_o[0]),  32'd0);
    drain(4);

    // Mask cleared and new event during ASSERT do not disturb the presented source
    done = 4'b0100;
    tick();
    tick();
    mask_we = 1'b1;
    mask_wdata = 4'b0000;
    done = 4'b0001;
    tick();
    tick();
    check("t5.irq",   32'(irq_o[0]), 32'd1);
    check("t5.id",    32'(id_o[0]),  32'd2);
    check("t5.eaddr", eaddr_o[0],    32'h108);
    iack[0] = 1'b1;
    iack[1] = 1'b1;
    tick();
    repeat (4) tick();
    check("t5.noirq_fp", 32'(irq_o[0]), 32'd0);
    check("t5.noirq_rr", 32'(irq_o[1]), 32'd0);
    mask_we = 1'b1;
    mask_wdata = 4'b1111;
    tick();
    drain(6);

    // Asynchronous reset in the middle of ASSERT
    done = 4'b0110;
    tick();
    tick();
    check("t6.irq_pre", 32'(irq_o[0]), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check("t6.irq",   32'(irq_o[m]),  32'd0);
      check("t6.pend",  32'(pend_o[m]), 32'd0);
      check("t6.eaddr", eaddr_o[m],     32'h100);
      check("t6.id",    32'(id_o[m]),   32'd0);
    end
    model_reset();
    rst = 1'b1;
    iack[0] = 1'b1;
    iack[1] = 1'b1;
    tick();
    check("t6.ack_ign", 32'(irq_o[0]), 32'd0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      done       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      mask_we    = ($urandom_range(0, 9) == 0);
      mask_wdata = 4'($urandom);
      iack[0]    = ($urandom_range(0, 2) == 0);
      iack[1]    = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/intc_vec.md
Name: intc_vec

Overview:
- Parametrised interrupt controller that aggregates N_SRC completion pulses from peripheral engines.
- Latches each pulse into a sticky pending bit and applies a per-source mask.
- Arbitrates by fixed priority or round-robin, then drives a single irq line to the CPU with a vector address.
- The CPU acknowledges with iack, which clears the serviced source and lets the next request be presented.

Parameters:
- N_SRC, 4: number of interrupt sources, 1..32.
- ADDR_W, 32: width of EAddr.
- VEC_BASE, 32'h0000_0100: vector address of source 0.
- VEC_STRIDE, 4: byte distance between consecutive vectors.
- RR_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- done  in  N_SRC  per-source event; each cycle done[i]=1 is sampled as one event.
- mask_we  in  1  when 1, mask_wdata is written to the mask register.
- mask_wdata  in  N_SRC  new mask value; 1 = source enabled.
- iack  in  1  CPU acknowledge, one-cycle pulse.
- irq  out  1  interrupt request to the CPU.
- EAddr  out  ADDR_W  vector address of the presented source.
- irq_id  out  $clog2(N_SRC) (min 1)  index of the presented source.
- pending  out  N_SRC  raw pending bits, for debug and status readback.

Behaviour:
- Reset (rst=0, async):
  - pending=0, mask=all ones, irq=0, EAddr=VEC_BASE, irq_id=0.
  - FSM=IDLE, round-robin pointer=0.
- Pending latch:
  - pending[i] is set at the edge where done[i]=1.
  - It is cleared only by an acknowledge of source i.
  - If set and clear hit the same edge, set wins: the event is retained and re-presented later.
- Mask:
  - Written on the edge where mask_we=1.
  - Masked sources still latch pending but do not request.
  - req = pending & mask.
- FSM states IDLE, ASSERT, GAP:
  - IDLE: if req != 0 at an edge, capture the winner: irq_id<=winner, EAddr<=VEC_BASE+winner*VEC_STRIDE (modulo 2^ADDR_W), irq<=1, go to ASSERT.
  - ASSERT: irq, irq_id and EAddr stay frozen. Later events, mask changes and clearing the mask bit of the presented source do not retract or change the presented request.
  - ASSERT exit: on the edge with iack=1, clear pending[irq_id] (subject to set-wins), set irq<=0, go to GAP.
  - GAP: one mandatory dead cycle with irq=0, then go to IDLE.
  - iack in IDLE or GAP is ignored with no state change.
- Latency:
  - done pulse at edge k gives pending at edge k+1 and irq at edge k+2.
  - iack at edge a gives irq low after a; the earliest re-assert is edge a+2.
- Arbitration:
  - RR_MODE=0: lowest set index of req wins.
  - RR_MODE=1: search starts at the pointer and wraps from N_SRC-1 to 0. On each acknowledge, pointer <= (irq_id+1) mod N_SRC.
- Datapath: EAddr and irq_id are registered only; there is no combinational path from done to irq.
- Reset mid-ASSERT: irq drops immediately (async) and all pending bits are lost.
- N_SRC=1: irq_id is constant 0 and both modes behave identically.

Test Plan:
1. Reset values, then a single done[2] pulse at edge 5 → pending=4'b0100 at edge 6; irq=1, irq_id=2, EAddr=0x108 at edge 7; iack at edge 9 → irq=0 and pending=0 after edge 9.
2. RR_MODE=0, done=4'b1010 in one cycle → first vector source 1 (0x104); after iack and GAP, source 3 (0x10C) at edge a+2; after the second iack, pending=0.
3. RR_MODE=1, done[0] held high for 10 cycles, done[1] pulsed once → sequence 0, then 1, then 0 again. Source 0 re-pends because set wins over clear; source 0 does not starve source 1.
4. mask_wdata=4'b1110, done[0] pulse → pending[0]=1 and irq stays 0. Then write mask=4'b1111 → irq=1, irq_id=0 two edges later.
5. During ASSERT on source 2, write mask=0 and pulse done[0] → irq_id stays 2 and EAddr is unchanged until iack. Afterwards no irq is raised while mask=0.
6. rst driven low mid-ASSERT, between clock edges → irq, pending and EAddr return to reset values without waiting for a clock edge. iack after rst is released has no effect.
